// File: rtl/pipe_stage_reg.sv
// Two-entry skid register between pipeline stages: a main (output) entry
// plus one skid entry, with flush, occupancy and a saturating stall counter.
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   in_valid/in_ready      upstream handshake; in_ctrl/in_data payload
//   flush                  synchronous kill of all held entries
//   out_valid/out_ready    downstream handshake; out_ctrl/out_data payload
//   occupancy              held entries (0..2)
//   stall_cnt              saturating count of upstream stall cycles
module pipe_stage_reg #(
    parameter int                CTRL_W     = 9,
    parameter int                DATA_W     = 143,
    parameter logic [CTRL_W-1:0] FLUSH_CTRL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding equals the entry count so occupancy comes straight off the flops.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state, state_nxt;
    logic              in_ready_q, in_ready_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl   <= FLUSH_CTRL;
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            main_ctrl   <= main_ctrl_nxt;
            main_data   <= main_data_nxt;
            skid_ctrl   <= skid_ctrl_nxt;
            skid_data   <= skid_data_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        cnt_nxt       = cnt;

        // Stall counting is independent of flush.
        if (in_valid && !in_ready_q && cnt != CNT_MAX) begin
            cnt_nxt = cnt + 1'b1;
        end

        if (flush) begin
            state_nxt     = EMPTY;
            main_ctrl_nxt = FLUSH_CTRL;
            main_data_nxt = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt     = ONE;
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_nxt = in_ctrl;
                        main_data_nxt = in_data;
                    end else if (in_xfer) begin
                        state_nxt     = FULL;
                        skid_ctrl_nxt = in_ctrl;
                        skid_data_nxt = in_data;
                    end else if (out_xfer) begin
                        state_nxt     = EMPTY;
                        main_ctrl_nxt = FLUSH_CTRL;
                        main_data_nxt = '0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt     = ONE;
                        main_ctrl_nxt = skid_ctrl;
                        main_data_nxt = skid_data;
                    end
                end
                default: begin
                    state_nxt     = EMPTY;
                    main_ctrl_nxt = FLUSH_CTRL;
                    main_data_nxt = '0;
                end
            endcase
        end

        // Handshake flags are precomputed so they leave the block as flops.
        in_ready_nxt  = (state_nxt != FULL);
        out_valid_nxt = (state_nxt != EMPTY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state;
    assign stall_cnt = cnt;

endmodule
